// File: rtl/fifo_ctrl.sv
// Push/pop control for an 8x10 dual-address RAM: strobes, pointers, occupancy flags, sticky errors.
// Latency: RAM strobes are combinational; read data and valid_out appear one cycle after re_a.
// Backpressure: writes are refused while full (unless a pop frees the slot); reads are refused while empty.
module fifo_ctrl #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  init,
    input  logic [3:0]            thr_high,
    input  logic [3:0]            thr_low,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    input  logic [DATA_WIDTH-1:0] q_a,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [ADDR_WIDTH-1:0] addr_wa,
    output logic [ADDR_WIDTH-1:0] addr_ra,
    output logic                  we_a,
    output logic                  re_a,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  error,
    output logic [3:0]            state
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int FW = CW + 4;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000,
        ST_ERROR  = 4'b1111
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [3:0]            thr_high_q, thr_low_q;
    logic                  valid_q;
    logic [DATA_WIDTH-1:0] hold_q;
    logic                  error_q;

    logic gate;
    logic full_w, empty_w;
    logic ovf_evt, unf_evt;

    assign gate    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE) || (state_q == ST_ERROR);
    assign full_w  = (count_q == DEPTH_C);
    assign empty_w = (count_q == '0);

    // A pop on a full FIFO frees the slot being written, so both proceed.
    assign re_a    = pop & gate & ~empty_w;
    assign we_a    = push & gate & (~full_w | re_a);
    assign ovf_evt = gate & push & full_w & ~pop;
    assign unf_evt = gate & pop & empty_w;

    assign data_a  = data_in;
    assign addr_wa = wr_ptr_q;
    assign addr_ra = rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (we_a) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (re_a) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({we_a, re_a})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RESET;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            thr_high_q <= 4'd6;
            thr_low_q  <= 4'd2;
            valid_q    <= 1'b0;
            hold_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= re_a;
            if (valid_q) begin
                hold_q <= q_a;
            end
            if (ovf_evt || unf_evt) begin
                error_q <= 1'b1;
            end
            case (state_q)
                ST_RESET: state_q <= ST_INIT;
                ST_INIT: begin
                    thr_high_q <= thr_high;
                    thr_low_q  <= thr_low;
                    if (!init) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_IDLE, ST_ACTIVE: begin
                    if (ovf_evt || unf_evt) begin
                        state_q <= ST_ERROR;
                    end else if (init) begin
                        state_q <= ST_INIT;
                    end else if (count_d == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_ACTIVE;
                    end
                end
                ST_ERROR: state_q <= ST_ERROR;
                default:  state_q <= ST_RESET;
            endcase
        end
    end

    // Read data is passed straight through in its valid cycle, then held.
    assign data_out     = valid_q ? q_a : hold_q;
    assign valid_out    = valid_q;
    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = FW'(count_q) >= FW'(thr_high_q);
    assign almost_empty = FW'(count_q) <= FW'(thr_low_q);
    assign fifo_count   = count_q;
    assign error        = error_q;
    assign state        = state_q;

endmodule
